ov7670_reg_sequencer: RTL

OV7670_REG_SEQUENCER -- requirements
Module: ov7670_reg_sequencer

---
 rtl/ov7670_reg_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ov7670_reg_sequencer.sv
// OV7670 register-table sequencer: walks one profile of a register table held
// in an external synchronous ROM and hands {reg, value} words to an SCCB master.
// Table words 16'hFFFF end the profile and 16'hFFF0 insert a DELAY_CYCLES pause.
module ov7670_reg_sequencer #(
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned PROF_W       = 2,
  parameter int unsigned DELAY_CYCLES = 2_500_000,
  parameter int unsigned AW           = PROF_W + $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     resend,
  input  logic [PROF_W-1:0]        profile,
  output logic [AW-1:0]            rom_addr,
  input  logic [15:0]              rom_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [15:0]              cmd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = IW + 1;
  localparam int unsigned DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_DELAY, S_DONE
  } state_t;

  state_t             state, state_next;
  logic [IW-1:0]      idx, idx_d, idx_inc;
  logic [PROF_W-1:0]  prof_l, prof_d;
  logic [DLY_W-1:0]   dly_cnt, dly_d;
  logic [AW-1:0]      addr_d;
  logic [15:0]        data_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               done_d, err_d, valid_d, busy_d;
  logic               last_entry, restart;

  assign idx_inc    = IW'(idx + 1'b1);
  assign last_entry = (idx == IW'(DEPTH - 1));
  // resend is meaningless before a profile has ever been latched
  assign restart    = resend && (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; resend overrides every other transition
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (rom_data == END_MARK)        state_next = S_DONE;
        else if (rom_data == DELAY_MARK) state_next = S_DELAY;
        else                             state_next = S_SEND;
      end
      S_SEND:   if (cmd_ready) state_next = last_entry ? S_DONE : S_FETCH;
      S_DELAY:  if (dly_cnt == '0) state_next = last_entry ? S_DONE : S_FETCH;
      S_DONE:   if (start) state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
    if (restart) state_next = S_FETCH;
  end

  // Output / datapath next values; the ROM address is set on entry to FETCH
  always_comb begin
    idx_d  = idx;
    prof_d = prof_l;
    dly_d  = dly_cnt;
    addr_d = rom_addr;
    data_d = cmd_data;
    cnt_d  = cmd_count;
    done_d = done;
    err_d  = error;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          prof_d = profile;
          idx_d  = '0;
          cnt_d  = '0;
          done_d = 1'b0;
          err_d  = 1'b0;
          addr_d = {profile, IW'(0)};
        end
      end
      S_DECODE: begin
        if (rom_data == END_MARK) begin
          done_d = 1'b1;
          err_d  = 1'b0;
        end else if (rom_data == DELAY_MARK) begin
          dly_d = DLY_W'(DELAY_CYCLES - 1);
        end else begin
          data_d = rom_data;
        end
      end
      S_SEND: begin
        if (cmd_ready) begin
          cnt_d = CNT_W'(cmd_count + 1'b1);
          if (last_entry) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            idx_d  = idx_inc;
            addr_d = {prof_l, idx_inc};
          end
        end
      end
      S_DELAY: begin
        if (dly_cnt == '0) begin
          if (last_entry) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            idx_d  = idx_inc;
            addr_d = {prof_l, idx_inc};
          end
        end else begin
          dly_d = DLY_W'(dly_cnt - 1'b1);
        end
      end
      default: ;
    endcase
    if (restart) begin
      prof_d = prof_l;
      idx_d  = '0;
      cnt_d  = '0;
      dly_d  = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
      addr_d = {prof_l, IW'(0)};
    end
    valid_d = (state_next == S_SEND);
    busy_d  = (state_next == S_FETCH) || (state_next == S_DECODE) ||
              (state_next == S_SEND)  || (state_next == S_DELAY);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      prof_l    <= '0;
      dly_cnt   <= '0;
      rom_addr  <= '0;
      cmd_data  <= '0;
      cmd_count <= '0;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      idx       <= idx_d;
      prof_l    <= prof_d;
      dly_cnt   <= dly_d;
      rom_addr  <= addr_d;
      cmd_data  <= data_d;
      cmd_count <= cnt_d;
      cmd_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= err_d;
    end
  end

endmodule
